// File: rtl/framebuffer_scanout_reader_pkg.sv
// Shared definitions for the framebuffer scanout reader: FSM states and default geometry.
package framebuffer_scanout_reader_pkg;

  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int DEF_ADDR_W = 19;
  localparam int DEF_DATA_W = 8;

  // sol, eol, eof travel with each pixel through the read pipe and FIFO
  localparam int FLAG_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scanout_skid_fifo.sv
// Two-entry output FIFO decoupling framebuffer reads from the pixel stream handshake.
module scanout_skid_fifo
  import framebuffer_scanout_reader_pkg::*;
#(
  parameter int W = DEF_DATA_W + FLAG_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         rd_q, wr_q;
  logic [1:0]   cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/framebuffer_scanout_reader.sv
// Scans a framebuffer line by line (optionally serpentine) and streams pixels with
// sol/eol/eof sideband over a valid/ready interface.
module framebuffer_scanout_reader
  import framebuffer_scanout_reader_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int SERPENTINE = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              abort,
  output logic              busy,
  output logic [ADDR_W-1:0] fb_address,
  output logic              fb_chipselect,
  input  logic [DATA_W-1:0] fb_readdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_eof
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int PW = DATA_W + FLAG_W;

  scan_state_e       state_q, state_d;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [ADDR_W-1:0] base_q;
  logic              inflight_q;
  logic [FLAG_W-1:0] flags_q;
  logic [1:0]        fifo_count;
  logic [PW-1:0]     head;
  logic [2:0]        occupancy;
  logic              issue, pop, line_end, frame_end, reverse;

  assign line_end  = (col_q == CW'(WIDTH - 1));
  assign frame_end = line_end && (row_q == RW'(HEIGHT - 1));
  assign reverse   = (SERPENTINE != 0) && row_q[0];

  assign pix_valid = (fifo_count != 2'd0);
  assign pop       = pix_valid && pix_ready;

  // A pop in the same cycle frees a slot, which is what sustains one pixel per cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = (state_q == ST_SCAN) && !abort && (occupancy < 3'd2);

  assign fb_chipselect = issue;
  assign fb_address    = reverse ? base_q + ADDR_W'(WIDTH - 1) - ADDR_W'(col_q)
                                 : base_q + ADDR_W'(col_q);
  assign busy          = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (frame_start) state_d = ST_SCAN;
      ST_SCAN:  if (issue && frame_end) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_count == 2'd0 && !inflight_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Line base advances by WIDTH per line; counters wrap to zero after the last read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else if (abort || state_q == ST_IDLE) begin
      col_q  <= '0;
      row_q  <= '0;
      base_q <= '0;
    end else if (issue) begin
      if (frame_end) begin
        col_q  <= '0;
        row_q  <= '0;
        base_q <= '0;
      end else if (line_end) begin
        col_q  <= '0;
        row_q  <= row_q + 1'b1;
        base_q <= base_q + ADDR_W'(WIDTH);
      end else begin
        col_q  <= col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
      flags_q    <= '0;
    end else begin
      inflight_q <= issue;
      flags_q    <= {col_q == '0, line_end, frame_end};
    end
  end

  scanout_skid_fifo #(.W(PW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (abort),
    .push    (inflight_q && !abort),
    .din     ({flags_q, fb_readdata}),
    .pop     (pop),
    .dout    (head),
    .count   (fifo_count)
  );

  assign {pix_sol, pix_eol, pix_eof, pix_data} = pix_valid ? head : '0;

endmodule

// File: tb/tb_framebuffer_scanout_reader.sv
// Scoreboard bench: a serpentine and a raster instance run in lockstep on shared stimulus.
module tb_framebuffer_scanout_reader;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0, reset_n = 1'b0, frame_start = 1'b0, abort = 1'b0, pix_ready = 1'b0;
  always #5 clk = ~clk;

  logic          busy1, cs1, valid1, sol1, eol1, eof1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] rd1 = '0, pd1;
  logic          busy0, cs0, valid0, sol0, eol0, eof0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] rd0 = '0, pd0;

  framebuffer_scanout_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .DATA_W(DW), .SERPENTINE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .abort(abort), .busy(busy1),
    .fb_address(addr1), .fb_chipselect(cs1), .fb_readdata(rd1), .pix_data(pd1),
    .pix_valid(valid1), .pix_ready(pix_ready), .pix_sol(sol1), .pix_eol(eol1), .pix_eof(eof1));

  framebuffer_scanout_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .DATA_W(DW), .SERPENTINE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .abort(abort), .busy(busy0),
    .fb_address(addr0), .fb_chipselect(cs0), .fb_readdata(rd0), .pix_data(pd0),
    .pix_valid(valid0), .pix_ready(pix_ready), .pix_sol(sol0), .pix_eol(eol0), .pix_eof(eof0));

  // 1-cycle latency RAM with mem[a] = a
  always @(posedge clk) begin
    if (cs1) rd1 <= DW'(addr1);
    if (cs0) rd0 <= DW'(addr0);
  end

  typedef struct { int d1; int d0; int flags; } exp_t;
  exp_t q[$];

  int checks = 0, errors = 0;
  int cyc = 0, hs = 0, start_cyc = 0, first_cyc = 0, last_cyc = 0, outst = 0;
  logic          prev_hold = 1'b0;
  logic [DW+2:0] prev_out  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: line r, k-th emitted pixel; odd lines reversed for the serpentine instance.
  function automatic void push_frame();
    exp_t e;
    for (int r = 0; r < H; r++)
      for (int k = 0; k < W; k++) begin
        e.d1    = r * W + (((r % 2) == 1) ? (W - 1 - k) : k);
        e.d0    = r * W + k;
        e.flags = ((k == 0) ? 4 : 0) + ((k == W - 1) ? 2 : 0) + ((k == W - 1 && r == H - 1) ? 1 : 0);
        q.push_back(e);
      end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic take;
    if (!reset_n) begin
      prev_hold = 1'b0;
      outst     = 0;
    end else begin
      take = valid1 && pix_ready;
      if (prev_hold) begin
        chk("hold_valid", valid1, 1);
        chk("hold_payload", {sol1, eol1, eof1, pd1}, prev_out);
      end
      if (valid1 || valid0) chk("lockstep_valid", valid0, valid1);
      if (take) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pixel actual=%0d expected=none (cycle %0d)", pd1, cyc);
        end else begin
          e = q.pop_front();
          chk("pixel_serp", pd1, e.d1);
          chk("pixel_raster", pd0, e.d0);
          chk("flags_serp", {sol1, eol1, eof1}, e.flags);
          chk("flags_raster", {sol0, eol0, eof0}, e.flags);
        end
        hs++;
        if (hs == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
      outst = outst + (cs1 ? 1 : 0) - (take ? 1 : 0);
      if (cs1) begin
        chk("outstanding_le2", (outst <= 2) ? 1 : 0, 1);
        chk("addr_bound", (addr1 <= W * H - 1) ? 1 : 0, 1);
      end
      if (abort) outst = 0;
      prev_hold = valid1 && !pix_ready && !abort;
      prev_out  = {sol1, eol1, eof1, pd1};
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_frame();
    tick();
    frame_start = 1'b1;
    start_cyc   = cyc + 1;
    hs          = 0;
    push_frame();
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_hs(input int n);
    int b = 0;
    while (hs < n && b < 200) begin tick(); b++; end
    chk("wait_hs_in_time", (hs >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input bit rnd);
    int b = 0;
    while ((busy1 || busy0 || q.size() != 0) && b < 300) begin
      if (rnd) pix_ready = 1'($urandom % 2);
      tick(); b++;
    end
    pix_ready = 1'b1;
    chk("idle_in_time", (b < 300) ? 1 : 0, 1);
    chk("frame_pixels", hs, W * H);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_busy"}, {busy1, busy0}, 0);
    chk({name, "_valid"}, {valid1, valid0}, 0);
  endtask

  initial begin
    int b;
    repeat (3) tick();
    chk("rst_busy_cs", {busy1, cs1, busy0, cs0}, 0);
    chk("rst_valid_flags", {valid1, sol1, eol1, eof1, valid0, sol0, eol0, eof0}, 0);
    chk("rst_addr", {addr1, addr0}, 0);
    chk("rst_data", {pd1, pd0}, 0);
    reset_n = 1'b1;

    // Full frame at full rate; frame_start held through the drain-to-idle edge
    pix_ready = 1'b1;
    start_frame();
    wait_hs(W * H);
    chk("first_latency_le2", (first_cyc - start_cyc <= 2) ? 1 : 0, 1);
    chk("throughput", last_cyc - first_cyc, W * H - 1);
    b = 0;
    do begin
      frame_start = busy1;
      if (busy1) tick();
      b++;
    end while (busy1 && b < 20);
    frame_start = 1'b0;
    repeat (4) tick();
    check_quiet("drain_start_ignored");
    chk("queue_empty_after_frame", q.size(), 0);

    // Back-pressure stall on pixel 2
    start_frame();
    wait_hs(2);
    pix_ready = 1'b0;
    repeat (5) tick();
    pix_ready = 1'b1;
    wait_idle(1'b0);

    // Random back-pressure
    start_frame();
    wait_idle(1'b1);

    // Abort after pixel 5, then restart
    start_frame();
    wait_hs(6);
    pix_ready = 1'b0;
    abort     = 1'b1;
    tick();
    abort = 1'b0;
    check_quiet("after_abort");
    q.delete();
    pix_ready = 1'b1;
    start_frame();
    wait_idle(1'b0);

    // frame_start during SCAN ignored
    start_frame();
    repeat (3) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    wait_idle(1'b0);
    repeat (5) tick();
    check_quiet("rescan_ignored");

    // abort wins over frame_start, from idle and mid-frame
    frame_start = 1'b1; abort = 1'b1;
    tick();
    frame_start = 1'b0; abort = 1'b0;
    check_quiet("abort_wins_idle");
    start_frame();
    repeat (4) tick();
    pix_ready = 1'b0; frame_start = 1'b1; abort = 1'b1;
    tick();
    frame_start = 1'b0; abort = 1'b0;
    check_quiet("abort_wins_scan");
    q.delete();
    pix_ready = 1'b1;
    repeat (3) tick();
    check_quiet("abort_stays_idle");

    // Reset pulse mid-frame
    start_frame();
    wait_hs(4);
    reset_n = 1'b0;
    #2;
    chk("midrst_outputs", {busy1, cs1, valid1, sol1, eol1, eof1, busy0, cs0, valid0}, 0);
    chk("midrst_addr_data", {addr1, pd1, addr0, pd0}, 0);
    q.delete();
    tick();
    reset_n = 1'b1;
    repeat (8) tick();
    check_quiet("after_reset");
    start_frame();
    wait_idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout_reader.md
FRAMEBUFFER_SCANOUT_READER -- requirements
Module: framebuffer_scanout_reader

Interface
REQ-001 Parameters SHALL be: WIDTH, default 640, pixels per line; HEIGHT, default 480, lines per frame; ADDR_W, default 19, framebuffer address width; DATA_W, default 8, pixel width; SERPENTINE, default 1, odd lines scanned right-to-left when 1.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 frame_start  input  1  one-cycle pulse; begins a frame scan when idle.
REQ-005 abort  input  1  synchronous; terminates the scan in progress.
REQ-006 busy  output  1  high while not in IDLE.
REQ-007 fb_address  output  ADDR_W  framebuffer port-2 read address.
REQ-008 fb_chipselect  output  1  read strobe to framebuffer port 2; write2 is tied low outside this block.
REQ-009 fb_readdata  input  DATA_W  framebuffer port-2 read data.
REQ-010 pix_data  output  DATA_W  streamed pixel value.
REQ-011 pix_valid  output  1  pix_data and sideband flags valid.
REQ-012 pix_ready  input  1  downstream accepts when pix_valid and pix_ready are both high.
REQ-013 pix_sol / pix_eol / pix_eof  output  1 each  first pixel of line / last pixel of line / last pixel of frame.

Function
REQ-014 FSM states SHALL be IDLE, SCAN and DRAIN.
REQ-015 IDLE to SCAN SHALL occur on frame_start; SCAN to DRAIN after the last read is issued; DRAIN to IDLE when the output FIFO is empty and no read is in flight.
REQ-016 frame_start SHALL be ignored outside IDLE.
REQ-017 Read latency SHALL be exactly 1: fb_readdata sampled the cycle after fb_chipselect is high belongs to that read.
REQ-018 Output buffering SHALL be a 2-entry FIFO.
REQ-019 A read SHALL issue only when FIFO occupancy plus in-flight reads is less than 2, so no data is ever dropped.
REQ-020 With pix_ready held high, throughput SHALL be 1 pixel per cycle after the first pixel.
REQ-021 The first pix_valid SHALL be no later than 2 cycles after frame_start.
REQ-022 pix_data and all flags SHALL be held stable while pix_valid is high and pix_ready is low.
REQ-023 Address for line r, column c SHALL be r*WIDTH+c.
REQ-024 When SERPENTINE=1 and r is odd, column order SHALL be reversed (c = WIDTH-1 down to 0).
REQ-025 The line base SHALL be accumulated by adding WIDTH per line; no multiplier.
REQ-026 fb_address SHALL never exceed WIDTH*HEIGHT-1 (307199 at defaults).
REQ-027 pix_sol SHALL be high on the first emitted pixel of each line and pix_eol on the last.
REQ-028 pix_eof SHALL coincide with pix_eol of line HEIGHT-1; exactly WIDTH*HEIGHT pixels are emitted per frame.
REQ-029 abort SHALL move any state to IDLE next cycle, flush the FIFO, discard in-flight read data, and drive pix_valid low.
REQ-030 abort SHALL take priority over a simultaneous frame_start.
REQ-031 frame_start on the same cycle as the DRAIN-to-IDLE transition SHALL be ignored.

Reset
REQ-032 On reset_n low: state IDLE; busy, fb_chipselect, pix_valid, pix_sol, pix_eol, pix_eof all 0; fb_address 0; pix_data 0; FIFO empty; counters 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame; no stale pixel SHALL appear after release.

Structure
REQ-034 A shared package SHALL hold the FSM state enum and the default WIDTH/HEIGHT/ADDR_W/DATA_W constants.
REQ-035 The 2-entry FIFO SHALL be a sub-module named scanout_skid_fifo; address generation and the FSM stay in the top module.

Verification (WIDTH=4, HEIGHT=3, SERPENTINE=1; 1-cycle-latency RAM model with mem[a]=a)
REQ-036 frame_start, pix_ready=1 -> 12 pixels in consecutive cycles: 0,1,2,3,7,6,5,4,8,9,10,11; sol on 0/7/8; eol on 3/4/11; eof on 11 only; busy falls after the last pixel.
REQ-037 Same run with SERPENTINE=0 -> pixels 0..11 in order.
REQ-038 pix_ready low for 5 cycles after pixel 2 -> pixel 2 held stable; no loss or duplication; at most 2 reads outstanding.
REQ-039 pix_ready random 50% -> sequence identical to REQ-036; exactly 12 handshakes.
REQ-040 abort after pixel 5 -> next cycle pix_valid=0, busy=0; following frame_start restarts at pixel 0.
REQ-041 frame_start during SCAN, and frame_start with abort in the same cycle -> ignored, and abort wins respectively; reset_n pulsed mid-frame -> all outputs 0, no pixels emitted until next frame_start.
